reg_transfer_sequencer: RTL and testbench

REG_TRANSFER_SEQUENCER -- requirements
Module: reg_transfer_sequencer

---
 rtl/reg_transfer_sequencer_pkg.sv | 39 +++
 rtl/reg_transfer_sequencer_sel.sv | 14 +
 rtl/reg_transfer_sequencer.sv | 127 ++++++++++++
 tb/tb_reg_transfer_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_transfer_sequencer_pkg.sv
// Shared encodings for the register-transfer sequencer.
// Optional feature: REGSEQ_INCDEC_EN makes INC/DEC legal operations.
package reg_transfer_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_MOV  = 3'b001,
    OP_SWAP = 3'b010,
    OP_CLR  = 3'b011,
    OP_INC  = 3'b100,
    OP_DEC  = 3'b101
  } op_e;

  localparam logic [2:0] FUN_DEC  = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_CLR  = 3'b011;

  localparam logic [3:0] SEL_NONE = 4'b1111;
  localparam logic [3:0] SEL_S1   = 4'b0111;
  localparam logic [2:0] OUTA_S1  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SWAP1,
    ST_SWAP2,
    ST_SWAP3
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef REGSEQ_INCDEC_EN
    return op <= 3'(OP_DEC);
`else
    return op <= 3'(OP_CLR);
`endif
  endfunction

endpackage

// File: rtl/reg_transfer_sequencer_sel.sv
// 2-bit register index to active-low one-cold write enable (bit 3 = R1).
module reg_sel_decoder
  import reg_transfer_sequencer_pkg::*;
(
  input  logic [1:0] idx,
  output logic [3:0] sel
);

  // Clear exactly the enable bit of the addressed register
  always_comb begin
    sel = SEL_NONE ^ (4'b1000 >> idx);
  end

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Register-transfer sequencer: turns LOAD/MOV/SWAP/CLR(/INC/DEC) requests
// into register-file control sequences. INC/DEC are legal only when
// REGSEQ_INCDEC_EN is defined.
module reg_transfer_sequencer
  import reg_transfer_sequencer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [2:0]  ReqOp,
  input  logic [1:0]  ReqDst,
  input  logic [1:0]  ReqSrc,
  input  logic [15:0] ReqData,
  input  logic [15:0] RfOutA,
  output logic [15:0] RfI,
  output logic [2:0]  RfFunSel,
  output logic [3:0]  RfRegSel,
  output logic [3:0]  RfScrSel,
  output logic [2:0]  RfOutASel,
  output logic [2:0]  RfOutBSel,
  output logic        Done,
  output logic        Err
);

  state_e      state;
  logic [2:0]  op_q;
  logic [1:0]  dst_q;
  logic [1:0]  src_q;
  logic [15:0] data_q;
  logic        done_q;
  logic        err_q;
  logic [3:0]  dst_sel;
  logic [3:0]  src_sel;

  reg_sel_decoder u_dst_dec (.idx(dst_q), .sel(dst_sel));
  reg_sel_decoder u_src_dec (.idx(src_q), .sel(src_sel));

  assign ReqReady  = (state == ST_IDLE);
  assign Done      = done_q;
  assign Err       = err_q;
  assign RfOutBSel = '0;

  // Sequencer state, request latch and registered completion pulse
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      dst_q  <= '0;
      src_q  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ReqValid) begin
            op_q   <= ReqOp;
            dst_q  <= ReqDst;
            src_q  <= ReqSrc;
            data_q <= ReqData;
            if (ReqOp == OP_SWAP) state <= ST_SWAP1;
            else                  state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state  <= ST_IDLE;
          done_q <= 1'b1;
          err_q  <= !op_legal(op_q);
        end
        ST_SWAP1: state <= ST_SWAP2;
        ST_SWAP2: state <= ST_SWAP3;
        ST_SWAP3: begin
          state  <= ST_IDLE;
          done_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register-file controls decoded from state and the latched request
  always_comb begin
    RfI       = '0;
    RfFunSel  = FUN_LOAD;
    RfRegSel  = SEL_NONE;
    RfScrSel  = SEL_NONE;
    RfOutASel = 3'b000;
    case (state)
      ST_EXEC: begin
        if (op_legal(op_q)) begin
          RfRegSel = dst_sel;
          case (op_q)
            OP_LOAD: RfI = data_q;
            OP_MOV: begin
              RfOutASel = {1'b0, src_q};
              RfI       = RfOutA;
            end
            OP_CLR:  RfFunSel = FUN_CLR;
            OP_INC:  RfFunSel = FUN_INC;
            OP_DEC:  RfFunSel = FUN_DEC;
            default: RfRegSel = SEL_NONE;
          endcase
        end
      end
      ST_SWAP1: begin
        RfOutASel = {1'b0, dst_q};
        RfScrSel  = SEL_S1;
        RfI       = RfOutA;
      end
      ST_SWAP2: begin
        RfOutASel = {1'b0, src_q};
        RfRegSel  = dst_sel;
        RfI       = RfOutA;
      end
      ST_SWAP3: begin
        RfOutASel = OUTA_S1;
        RfRegSel  = src_sel;
        RfI       = RfOutA;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Directed self-checking bench for reg_transfer_sequencer with a small
// behavioural register file (R1..R4, S1) attached to its control outputs.
module tb_reg_transfer_sequencer;
  import reg_transfer_sequencer_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [2:0]  ReqOp;
  logic [1:0]  ReqDst;
  logic [1:0]  ReqSrc;
  logic [15:0] ReqData;
  logic [15:0] RfOutA;
  logic [15:0] RfI;
  logic [2:0]  RfFunSel;
  logic [3:0]  RfRegSel;
  logic [3:0]  RfScrSel;
  logic [2:0]  RfOutASel;
  logic [2:0]  RfOutBSel;
  logic        Done;
  logic        Err;

  int checks = 0;
  int errors = 0;

  reg_transfer_sequencer dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp(ReqOp), .ReqDst(ReqDst), .ReqSrc(ReqSrc), .ReqData(ReqData),
    .RfOutA(RfOutA), .RfI(RfI), .RfFunSel(RfFunSel), .RfRegSel(RfRegSel),
    .RfScrSel(RfScrSel), .RfOutASel(RfOutASel), .RfOutBSel(RfOutBSel),
    .Done(Done), .Err(Err)
  );

  always #5 Clock = ~Clock;

  // Register-file model
  logic [15:0] rf [4];
  logic [15:0] s1;

  function automatic logic [15:0] rf_next(input logic [2:0] fs,
                                          input logic [15:0] cur,
                                          input logic [15:0] din);
    case (fs)
      3'b000:  return cur - 16'd1;
      3'b001:  return cur + 16'd1;
      3'b010:  return din;
      3'b011:  return 16'h0000;
      default: return cur;
    endcase
  endfunction

  always_comb begin
    case (RfOutASel)
      3'b000, 3'b001, 3'b010, 3'b011: RfOutA = rf[RfOutASel[1:0]];
      3'b100:  RfOutA = s1;
      default: RfOutA = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    for (int i = 0; i < 4; i++)
      if (!RfRegSel[3-i]) rf[i] <= rf_next(RfFunSel, rf[i], RfI);
    if (!RfScrSel[3]) s1 <= rf_next(RfFunSel, s1, RfI);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Present a request in IDLE and return #1 after the accepting edge
  task automatic accept(input logic [2:0] op, input logic [1:0] dst,
                        input logic [1:0] src, input logic [15:0] data);
    ReqValid = 1'b1;
    ReqOp    = op;
    ReqDst   = dst;
    ReqSrc   = src;
    ReqData  = data;
    step();
    ReqValid = 1'b0;
  endtask

  // Cycles from accept edge until Done is seen, bounded
  task automatic wait_done(output int lat, output logic err);
    lat = 1;
    while (Done !== 1'b1 && lat < 12) begin
      step();
      lat++;
    end
    err = Err;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] dst,
                        input logic [1:0] src, input logic [15:0] data,
                        input int exp_lat, input logic exp_err);
    int   lat;
    logic err;
    accept(op, dst, src, data);
    wait_done(lat, err);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    int   lat;
    logic err;
    Reset = 1'b0; ReqValid = 1'b0; ReqOp = '0; ReqDst = '0; ReqSrc = '0; ReqData = '0;
    #3;
    check("rst_ready",  32'(ReqReady), 32'd1);
    check("rst_done",   32'(Done),     32'd0);
    check("rst_err",    32'(Err),      32'd0);
    check("rst_regsel", 32'(RfRegSel), 32'hF);
    check("rst_scrsel", 32'(RfScrSel), 32'hF);
    check("outbsel",    32'(RfOutBSel), 32'd0);
    step();
    Reset = 1'b1;
    step();

    // LOAD R2, 0x1234
    accept(OP_LOAD, 2'd1, 2'd0, 16'h1234);
    check("load_regsel", 32'(RfRegSel), 32'hB);
    check("load_funsel", 32'(RfFunSel), 32'h2);
    check("load_rfi",    32'(RfI),      32'h1234);
    check("load_scrsel", 32'(RfScrSel), 32'hF);
    check("load_ready",  32'(ReqReady), 32'd0);
    wait_done(lat, err);
    check("load_lat",    32'(lat), 32'd2);
    check("load_err",    32'(err), 32'd0);
    check("load_dready", 32'(ReqReady), 32'd1);
    check("load_r2",     32'(rf[1]), 32'h1234);
    step();
    check("done_pulse",  32'(Done), 32'd0);

    // MOV R4 <- R2
    accept(OP_MOV, 2'd3, 2'd1, 16'h0000);
    check("mov_outasel", 32'(RfOutASel), 32'h1);
    check("mov_regsel",  32'(RfRegSel),  32'hE);
    check("mov_rfi",     32'(RfI),       32'h1234);
    wait_done(lat, err);
    check("mov_lat", 32'(lat), 32'd2);
    check("mov_r4",  32'(rf[3]), 32'h1234);
    check("mov_r2",  32'(rf[1]), 32'h1234);

    // SWAP R1, R3
    run_op("ld_r1", OP_LOAD, 2'd0, 2'd0, 16'hAAAA, 2, 1'b0);
    run_op("ld_r3", OP_LOAD, 2'd2, 2'd0, 16'h5555, 2, 1'b0);
    accept(OP_SWAP, 2'd0, 2'd2, 16'h0000);
    check("sw1_ready",  32'(ReqReady),  32'd0);
    check("sw1_scr",    32'(RfScrSel),  32'h7);
    check("sw1_outa",   32'(RfOutASel), 32'h0);
    check("sw1_regsel", 32'(RfRegSel),  32'hF);
    step();
    check("sw2_ready",  32'(ReqReady),  32'd0);
    check("sw2_outa",   32'(RfOutASel), 32'h2);
    check("sw2_regsel", 32'(RfRegSel),  32'h7);
    step();
    check("sw3_ready",  32'(ReqReady),  32'd0);
    check("sw3_outa",   32'(RfOutASel), 32'h4);
    check("sw3_regsel", 32'(RfRegSel),  32'hD);
    check("sw3_funsel", 32'(RfFunSel),  32'h2);
    step();
    check("swap_done",  32'(Done), 32'd1);
    check("swap_err",   32'(Err),  32'd0);
    check("swap_ready", 32'(ReqReady), 32'd1);
    check("swap_r1", 32'(rf[0]), 32'h5555);
    check("swap_r3", 32'(rf[2]), 32'hAAAA);
    check("swap_s1", 32'(s1),    32'hAAAA);

    // Dst == Src
    run_op("mov_same",  OP_MOV,  2'd1, 2'd1, 16'h0000, 2, 1'b0);
    check("mov_same_r2", 32'(rf[1]), 32'h1234);
    run_op("swap_same", OP_SWAP, 2'd1, 2'd1, 16'h0000, 4, 1'b0);
    check("swap_same_r2", 32'(rf[1]), 32'h1234);

    // CLR R3
    run_op("clr", OP_CLR, 2'd2, 2'd0, 16'h0000, 2, 1'b0);
    check("clr_r3", 32'(rf[2]), 32'h0000);

    // Illegal op 110
    accept(3'b110, 2'd0, 2'd0, 16'hFFFF);
    check("ill_regsel", 32'(RfRegSel), 32'hF);
    check("ill_scrsel", 32'(RfScrSel), 32'hF);
    wait_done(lat, err);
    check("ill_lat", 32'(lat), 32'd2);
    check("ill_err", 32'(err), 32'd1);
    check("ill_r1",  32'(rf[0]), 32'h5555);
    run_op("ill7", 3'b111, 2'd0, 2'd0, 16'h0000, 2, 1'b1);

    // INC / DEC
    run_op("ld_ffff", OP_LOAD, 2'd0, 2'd0, 16'hFFFF, 2, 1'b0);
`ifdef REGSEQ_INCDEC_EN
    run_op("inc", OP_INC, 2'd0, 2'd0, 16'h0000, 2, 1'b0);
    check("inc_r1", 32'(rf[0]), 32'h0000);
    run_op("dec", OP_DEC, 2'd0, 2'd0, 16'h0000, 2, 1'b0);
    check("dec_r1", 32'(rf[0]), 32'hFFFF);
`else
    accept(OP_INC, 2'd0, 2'd0, 16'h0000);
    check("inc_regsel", 32'(RfRegSel), 32'hF);
    wait_done(lat, err);
    check("inc_lat", 32'(lat), 32'd2);
    check("inc_err", 32'(err), 32'd1);
    run_op("dec", OP_DEC, 2'd0, 2'd0, 16'h0000, 2, 1'b1);
    check("incdec_r1", 32'(rf[0]), 32'hFFFF);
`endif

    // Back-to-back LOADs with ReqValid held
    ReqValid = 1'b1; ReqOp = OP_LOAD; ReqDst = 2'd0; ReqData = 16'h00A1;
    step();
    check("b2b_c1_done", 32'(Done), 32'd0);
    ReqDst = 2'd1; ReqData = 16'h00B2;
    step();
    check("b2b_c2_done",  32'(Done), 32'd1);
    check("b2b_c2_ready", 32'(ReqReady), 32'd1);
    step();
    ReqValid = 1'b0;
    check("b2b_c3_done",  32'(Done), 32'd0);
    check("b2b_c3_ready", 32'(ReqReady), 32'd0);
    step();
    check("b2b_c4_done", 32'(Done), 32'd1);
    check("b2b_r1", 32'(rf[0]), 32'h00A1);
    check("b2b_r2", 32'(rf[1]), 32'h00B2);

    // Reset during SWAP2
    run_op("ld_1111", OP_LOAD, 2'd0, 2'd0, 16'h1111, 2, 1'b0);
    run_op("ld_2222", OP_LOAD, 2'd1, 2'd0, 16'h2222, 2, 1'b0);
    accept(OP_SWAP, 2'd0, 2'd1, 16'h0000);
    step();
    Reset = 1'b0;
    #1;
    check("ar_ready",  32'(ReqReady), 32'd1);
    check("ar_regsel", 32'(RfRegSel), 32'hF);
    check("ar_scrsel", 32'(RfScrSel), 32'hF);
    check("ar_done",   32'(Done),     32'd0);
    step();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ar_nodone", 32'(Done), 32'd0);
    end
    check("ar_s1", 32'(s1),    32'h1111);
    check("ar_r1", 32'(rf[0]), 32'h1111);
    check("ar_r2", 32'(rf[1]), 32'h2222);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
